// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type and default sizing for the UART transmit arbiter
package uart_tx_pkg;
  localparam int UART_DATA_W      = 8;
  localparam int UART_MAX_PKT_LEN = 64;
  typedef enum logic [2:0] {IDLE, SEND, GUARD, CKSUM, DONE} state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick
// Ports: valid[1:0] request bits, ptr preferred requester, grant one-hot winner or 0.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb grant = (ptr ? valid[1] : valid[0]) ? (ptr ? 2'b10 : 2'b01)
                                                  : (ptr ? {1'b0, valid[0]} : {valid[1], 1'b0});
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin arbiter feeding packet bytes to a UART transmitter
// Ports: CLK100MHZ clock; reset sync active-high; start enables new grants;
//   req_valid/req_data/req_last/req_ready per-requester byte streams;
//   tx_ready/tx_start/tx_data transmitter load handshake;
//   grant one-hot owner; pkt_done end-of-packet pulse; err_trunc forced-end pulse.
// Build option: UART_TX_ARBITER_CHECKSUM_EN appends an XOR checksum byte to every packet.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int DATA_W      = UART_DATA_W,
  parameter int MAX_PKT_LEN = UART_MAX_PKT_LEN
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [1:0]          req_last,
  output logic [1:0]          req_ready,
  input  logic                tx_ready,
  output logic                tx_start,
  output logic [DATA_W-1:0]   tx_data,
  output logic [1:0]          grant,
  output logic                pkt_done,
  output logic                err_trunc
);
  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  state_t r_state, w_next;
  logic [1:0] r_grant, w_pick;
  logic r_ptr, r_last, w_gi, w_xfer, w_full, w_ck_tx, w_ck_sent;
  logic [CW-1:0] r_cnt;
  logic [DATA_W-1:0] w_byte, w_ck;
  rr_pick2 u_pick (.valid(req_valid), .ptr(r_ptr), .grant(w_pick));
  assign w_gi      = r_grant[1];
  assign w_byte    = w_gi ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
  assign req_ready = (r_state == SEND) ? (r_grant & {2{tx_ready}}) : 2'b00;
  assign w_xfer    = |(req_valid & req_ready);
  assign w_full    = r_cnt == CW'(MAX_PKT_LEN);
`ifdef UART_TX_ARBITER_CHECKSUM_EN
  localparam state_t LAST_ST = CKSUM;
  logic [DATA_W-1:0] r_ck;
  logic r_ck_sent;
  assign w_ck_tx   = (r_state == CKSUM) && tx_ready;
  assign w_ck      = r_ck;
  assign w_ck_sent = r_ck_sent;
  // r_ck_sent marks that the GUARD in progress follows the checksum byte, not a data byte
  always_ff @(posedge CLK100MHZ) begin
    if (reset || r_state == DONE) begin
      r_ck      <= '0;
      r_ck_sent <= 1'b0;
    end else begin
      if (w_xfer) r_ck <= r_ck ^ w_byte;
      if (w_ck_tx) r_ck_sent <= 1'b1;
    end
  end
`else
  localparam state_t LAST_ST = DONE;
  assign w_ck_tx   = 1'b0;
  assign w_ck      = '0;
  assign w_ck_sent = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (start && w_pick != 2'b00) ? SEND : IDLE;
      SEND:    w_next = w_xfer ? GUARD : SEND;
      GUARD:   w_next = w_ck_sent ? DONE : (r_last || w_full) ? LAST_ST : SEND;
`ifdef UART_TX_ARBITER_CHECKSUM_EN
      CKSUM:   w_next = tx_ready ? GUARD : CKSUM;
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == SEND) r_grant <= w_pick;
      if (w_xfer) begin
        r_cnt  <= w_full ? r_cnt : r_cnt + CW'(1);
        r_last <= req_last[w_gi];
      end
      // pointer hands priority to the requester that did not just own the transmitter
      if (r_state == DONE) begin
        r_grant <= '0;
        r_cnt   <= '0;
        r_ptr   <= r_grant[0];
      end
    end
  end
  assign tx_start  = w_xfer || w_ck_tx;
  assign tx_data   = w_xfer ? w_byte : (w_ck_tx ? w_ck : '0);
  assign grant     = r_grant;
  assign pkt_done  = r_state == DONE;
  assign err_trunc = (r_state == GUARD) && w_full && !r_last && !w_ck_sent;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench for uart_tx_arbiter against a packet-level model
module tb_uart_tx_arbiter;
  localparam int DW  = 8;
  localparam int MAX = 64;
`ifdef UART_TX_ARBITER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, start, tx_ready, tx_start, pkt_done, err_trunc;
  logic [1:0] req_valid, req_last, req_ready, grant;
  logic [2*DW-1:0] req_data;
  logic [DW-1:0] tx_data;
  logic [8:0] rq0[$], rq1[$];
  int ev[$], exp_q[$];
  int checks = 0, errors = 0, busy = 0, stall_bad = 0;
  bit tx_hold = 0, chk_hold = 0, gap_en = 0;

  uart_tx_arbiter #(.DATA_W(DW), .MAX_PKT_LEN(MAX)) dut (
    .CLK100MHZ(clk), .reset(reset), .start(start),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .grant(grant), .pkt_done(pkt_done), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  // requester queues, transmitter model and event monitor
  initial begin
    logic [1:0] acc, drop;
    logic txs;
    logic [8:0] tmp;
    tx_ready = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      txs = tx_start;
      for (int i = 0; i < 2; i++) drop[i] = gap_en && grant[i] && !pkt_done && ($urandom_range(0, 3) == 0);
      if (chk_hold && (req_ready != 2'b00 || tx_start)) stall_bad++;
      if (tx_start) ev.push_back(int'(tx_data));
      if (err_trunc) ev.push_back(256);
      if (pkt_done) ev.push_back(257);
      @(posedge clk); #1;
      if (acc[0] && rq0.size() != 0) tmp = rq0.pop_front();
      if (acc[1] && rq1.size() != 0) tmp = rq1.pop_front();
      busy = txs ? int'($urandom_range(1, 4)) : (busy > 0 ? busy - 1 : 0);
      tx_ready = !tx_hold && busy == 0;
      req_valid[0] = rq0.size() != 0 && !drop[0];
      req_valid[1] = rq1.size() != 0 && !drop[1];
      req_data[7:0]  = rq0.size() != 0 ? rq0[0][7:0] : 8'h00;
      req_data[15:8] = rq1.size() != 0 ? rq1[0][7:0] : 8'h00;
      req_last[0] = rq0.size() != 0 ? rq0[0][8] : 1'b0;
      req_last[1] = rq1.size() != 0 ? rq1[0][8] : 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // packet-level model: pick by pointer, cut at last or MAX bytes, alternate owners
  task automatic ref_model();
    logic [8:0] c0[$], c1[$], e;
    logic [7:0] ck;
    int p, g, n;
    bit fin;
    c0 = rq0; c1 = rq1; exp_q.delete(); p = 0;
    while (c0.size() != 0 || c1.size() != 0) begin
      g = (p == 0) ? (c0.size() != 0 ? 0 : 1) : (c1.size() != 0 ? 1 : 0);
      n = 0; ck = 8'h00; fin = 0;
      while (!fin) begin
        if (g == 0 ? c0.size() == 0 : c1.size() == 0) return;
        e = g == 0 ? c0.pop_front() : c1.pop_front();
        exp_q.push_back(int'(e[7:0]));
        ck ^= e[7:0];
        n++;
        if (e[8]) fin = 1;
        else if (n == MAX) begin exp_q.push_back(256); fin = 1; end
      end
      if (CK_EN) exp_q.push_back(int'(ck));
      exp_q.push_back(257);
      p = 1 - g;
    end
  endtask

  task automatic push_pkt(input int r, input int n, input logic [7:0] base, input bit rnd, input bit with_last);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      e = {with_last && i == n - 1, rnd ? 8'($urandom) : base + 8'(i)};
      if (r == 0) rq0.push_back(e); else rq1.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; rq0.delete(); rq1.delete();
    @(posedge clk); #1;
    reset = 1'b0; ev.delete();
  endtask

  task automatic wait_ev(input int budget);
    int t = 0;
    while (ev.size() < exp_q.size() && t < budget) begin @(posedge clk); t++; end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    if (err_trunc !== 1'b0) begin errors++; $display("FAIL reset_err_trunc: got %b want 0", err_trunc); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    push_pkt(0, 3, 8'h41, 0, 1);
    ref_model();
    wait_ev(2000);
    checks++;
    if (ev.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d events want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      checks++;
      if (ev[i] !== exp_q[i]) begin errors++; $display("FAIL basic_ev%0d: got %0d want %0d", i, ev[i], exp_q[i]); end
    end
  endtask

  task automatic test_both();
    do_reset();
    push_pkt(0, 2, 8'hA0, 0, 1);
    push_pkt(1, 3, 8'hB0, 0, 1);
    push_pkt(0, 2, 8'hC0, 0, 1);
    ref_model();
    @(posedge clk); @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL both_first_grant: got %b want 01", grant); end
    wait_ev(3000);
    checks++;
    if (ev.size() != exp_q.size()) begin errors++; $display("FAIL both_count: got %0d events want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      checks++;
      if (ev[i] !== exp_q[i]) begin errors++; $display("FAIL both_ev%0d: got %0d want %0d", i, ev[i], exp_q[i]); end
    end
  endtask

  task automatic test_trunc();
    do_reset();
    push_pkt(1, 70, 8'h00, 1, 0);
    ref_model();
    wait_ev(5000);
    checks++;
    if (ev.size() != exp_q.size()) begin errors++; $display("FAIL trunc_count: got %0d events want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      checks++;
      if (ev[i] !== exp_q[i]) begin errors++; $display("FAIL trunc_ev%0d: got %0d want %0d", i, ev[i], exp_q[i]); end
    end
  endtask

  task automatic test_start();
    int t = 0;
    start = 1'b0;
    do_reset();
    push_pkt(0, 4, 8'h50, 0, 1);
    ref_model();
    push_pkt(1, 2, 8'h60, 0, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (ev.size() != 0) begin errors++; $display("FAIL start_blocked_ev: got %0d events want 0", ev.size()); end
    if (grant !== 2'b00) begin errors++; $display("FAIL start_blocked_grant: got %b want 00", grant); end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL start_grant: got %b want 01", grant); end
    while (ev.size() < 1 && t < 200) begin @(posedge clk); t++; end
    #1 start = 1'b0;
    wait_ev(2000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL start_after_grant: got %b want 00", grant); end
    checks++;
    if (ev.size() != exp_q.size()) begin errors++; $display("FAIL start_count: got %0d events want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      checks++;
      if (ev[i] !== exp_q[i]) begin errors++; $display("FAIL start_ev%0d: got %0d want %0d", i, ev[i], exp_q[i]); end
    end
    start = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    do_reset();
    push_pkt(0, 1, 8'h11, 0, 1);
    ref_model();
    wait_ev(1000);
    @(posedge clk); #1;
    ev.delete();
    push_pkt(1, 5, 8'h70, 0, 1);
    while (ev.size() < 2 && t < 500) begin @(posedge clk); t++; end
    #1 reset = 1'b1; rq0.delete(); rq1.delete();
    @(posedge clk); @(negedge clk);
    checks++;
    if ({grant, req_ready, tx_start, tx_data, pkt_done, err_trunc} !== '0)
      begin errors++; $display("FAIL midreset_outputs: got %b/%b/%b/%h/%b/%b want all 0", grant, req_ready, tx_start, tx_data, pkt_done, err_trunc); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    checks++;
    if (ev.size() != 2) begin errors++; $display("FAIL midreset_events: got %0d events want 2", ev.size()); end
    ev.delete();
    push_pkt(0, 1, 8'h21, 0, 1);
    push_pkt(1, 1, 8'h31, 0, 1);
    ref_model();
    @(posedge clk); @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL midreset_ptr: got %b want 01", grant); end
    wait_ev(1000);
    checks++;
    if (ev.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count: got %0d events want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      checks++;
      if (ev[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_ev%0d: got %0d want %0d", i, ev[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    tx_hold = 1;
    do_reset();
    push_pkt(0, 5, 8'h00, 1, 1);
    push_pkt(1, 4, 8'h00, 1, 1);
    ref_model();
    stall_bad = 0;
    chk_hold = 1;
    repeat (500) @(posedge clk);
    chk_hold = 0;
    checks += 2;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_quiet: got %0d active cycles want 0", stall_bad); end
    if (ev.size() != 0) begin errors++; $display("FAIL stall_events: got %0d events want 0", ev.size()); end
    tx_hold = 0;
    wait_ev(3000);
    checks++;
    if (ev.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d events want %0d", ev.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
      checks++;
      if (ev[i] !== exp_q[i]) begin errors++; $display("FAIL stall_ev%0d: got %0d want %0d", i, ev[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      gap_en = 1;
      for (int q = 0; q < 2; q++)
        repeat ($urandom_range(1, 3)) push_pkt(q, int'($urandom_range(1, 12)), 8'h00, 1, 1);
      ref_model();
      wait_ev(6000);
      gap_en = 0;
      checks++;
      if (ev.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d events want %0d", r, ev.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev.size(); i++) begin
        checks++;
        if (ev[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_ev%0d: got %0d want %0d", r, i, ev[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1;
    test_reset();
    test_basic();
    test_both();
    test_trunc();
    test_start();
    test_reset_mid();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
